// File: rtl/marco_initiator.sv
// MARCO/POLO handshake initiator: sends "MARCO" as 8N1 frames on tx, then
// waits a bounded number of bit periods for "POLO" on the received byte stream.
module marco_initiator #(
   parameter int TIMEOUT_TICKS = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       start,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       timeout
);

   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t          state;
   logic [2:0]      char_idx;
   logic [3:0]      bit_idx;
   logic [2:0]      match_idx;
   logic [TW-1:0]   tick_cnt;
   logic [7:0]      tx_byte;
   logic [7:0]      exp_byte;
   logic [2:0]      match_next;

   always_comb begin
      tx_byte = 8'h4D;
      case (char_idx)
         3'd0:    tx_byte = 8'h4D;
         3'd1:    tx_byte = 8'h41;
         3'd2:    tx_byte = 8'h52;
         3'd3:    tx_byte = 8'h43;
         3'd4:    tx_byte = 8'h4F;
         default: tx_byte = 8'h4D;
      endcase
   end

   always_comb begin
      exp_byte = 8'h50;
      case (match_idx)
         3'd0:    exp_byte = 8'h50;
         3'd1:    exp_byte = 8'h4F;
         3'd2:    exp_byte = 8'h4C;
         3'd3:    exp_byte = 8'h4F;
         default: exp_byte = 8'h50;
      endcase
   end

   // A stray 'P' can always begin a fresh "POLO", so it restarts the match at 1.
   always_comb begin
      match_next = 3'd0;
      if (rx_data == exp_byte)
         match_next = match_idx + 3'd1;
      else if (rx_data == 8'h50)
         match_next = 3'd1;
   end

   // bit_idx: 0 = start bit pending, 1..8 = data bits, 9 = stop bit, 10 = stop bit on the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         char_idx  <= 3'd0;
         bit_idx   <= 4'd0;
         match_idx <= 3'd0;
         tick_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (start) begin
                  state    <= SEND;
                  char_idx <= 3'd0;
                  bit_idx  <= 4'd0;
                  pass     <= 1'b0;
                  timeout  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SEND: begin
               if (baud_tick) begin
                  if (bit_idx == 4'd0) begin
                     tx      <= 1'b0;
                     bit_idx <= 4'd1;
                  end else if (bit_idx <= 4'd8) begin
                     tx      <= tx_byte[3'(bit_idx - 4'd1)];
                     bit_idx <= bit_idx + 4'd1;
                  end else if (bit_idx == 4'd9) begin
                     tx      <= 1'b1;
                     bit_idx <= 4'd10;
                  end else if (char_idx == 3'd4) begin
                     state     <= WAIT;
                     tx        <= 1'b1;
                     match_idx <= 3'd0;
                     tick_cnt  <= '0;
                  end else begin
                     char_idx <= char_idx + 3'd1;
                     tx       <= 1'b0;
                     bit_idx  <= 4'd1;
                  end
               end
            end
            WAIT: begin
               tx <= 1'b1;
               if (rx_valid && match_next == 3'd4) begin
                  state <= IDLE;
                  done  <= 1'b1;
                  pass  <= 1'b1;
                  busy  <= 1'b0;
               end else if (baud_tick && tick_cnt == TICK_LAST) begin
                  state   <= IDLE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  if (rx_valid)
                     match_idx <= match_next;
                  if (baud_tick)
                     tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_marco_initiator.sv
// Directed and randomized bench for marco_initiator; tx is decoded back into
// bytes and the reply is judged by a sliding-window "POLO" search.
module tb_marco_initiator;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic       start;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx;
   logic       busy;
   logic       done;
   logic       pass;
   logic       timeout;

   int tests = 0;
   int failures = 0;

   int         ev_cyc[$];
   logic [7:0] ev_byte[$];
   logic [7:0] msg[5];

   marco_initiator #(.TIMEOUT_TICKS(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx        (tx),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic applyStimulus(input logic bt, input logic st, input logic rv, input logic [7:0] rd);
      @(negedge clk);
      baud_tick = bt;
      start     = st;
      rx_valid  = rv;
      rx_data   = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic e_tx, input logic e_busy,
                              input logic e_done, input logic e_pass, input logic e_to);
      check({tag, "_tx"},      tx,      e_tx);
      check({tag, "_busy"},    busy,    e_busy);
      check({tag, "_done"},    done,    e_done);
      check({tag, "_pass"},    pass,    e_pass);
      check({tag, "_timeout"}, timeout, e_to);
   endtask

   task automatic do_start();
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      check("start_busy", busy, 1'b1);
      check("start_tx", tx, 1'b1);
      check("start_clr_pass", pass, 1'b0);
      check("start_clr_timeout", timeout, 1'b0);
   endtask

   task automatic run_send(input bit pulse_start, input bit inject_rx);
      logic bits[$];
      logic bt, st, rv, prev;
      logic [7:0] rd, b;
      int ticks = 0, glitch = 0, busy_drop = 0, c = 0;
      prev = tx;
      while (ticks < 51 && c < 400) begin
         c++;
         bt = (c % 4 == 0);
         st = pulse_start && (c == 42 || c == 43);
         rv = inject_rx && (c == 13 || c == 53 || c == 93 || c == 133);
         rd = (c == 13) ? 8'h50 : (c == 53) ? 8'h4F : (c == 93) ? 8'h4C : 8'h4F;
         applyStimulus(bt, st, rv, rd);
         if (!busy) busy_drop++;
         if (bt) begin
            ticks++;
            if (ticks <= 50) bits.push_back(tx);
            else begin
               check("wait_entry_tx", tx, 1'b1);
               check("wait_entry_busy", busy, 1'b1);
            end
         end else if (tx !== prev) glitch++;
         prev = tx;
      end
      check("send_ticks", ticks, 51);
      check("send_tx_between_ticks", glitch, 0);
      check("send_busy_drop", busy_drop, 0);
      if (bits.size() == 50) begin
         for (int f = 0; f < 5; f++) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b[i] = bits[f*10 + 1 + i];
            check($sformatf("frame%0d_start", f), bits[f*10], 1'b0);
            check($sformatf("frame%0d_data", f), b, msg[f]);
            check($sformatf("frame%0d_stop", f), bits[f*10 + 9], 1'b1);
         end
      end
   endtask

   // Reply model: pass once the last four accepted bytes spell "POLO", else timeout on the TO-th tick.
   task automatic run_wait(input string name);
      logic [7:0] win[$];
      logic bt, rv;
      logic [7:0] rd;
      int ticks = 0;
      bit decided = 0, exp_pass = 0, exp_to = 0;
      for (int c = 1; c <= 200 && !decided; c++) begin
         bt = (c % 4 == 0);
         rv = 1'b0;
         rd = 8'h00;
         for (int i = 0; i < ev_cyc.size(); i++)
            if (ev_cyc[i] == c) begin
               rv = 1'b1;
               rd = ev_byte[i];
            end
         applyStimulus(bt, 1'b0, rv, rd);
         if (rv) begin
            win.push_back(rd);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4 && win[0] == 8'h50 && win[1] == 8'h4F &&
                win[2] == 8'h4C && win[3] == 8'h4F) begin
               decided  = 1;
               exp_pass = 1;
            end
         end
         if (!decided && bt) begin
            ticks++;
            if (ticks == TO) begin
               decided = 1;
               exp_to  = 1;
            end
         end
         check({name, "_done"}, done, decided);
      end
      check({name, "_pass"}, pass, exp_pass);
      check({name, "_timeout"}, timeout, exp_to);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_tx"}, tx, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      check({name, "_done_one_cycle"}, done, 1'b0);
      check({name, "_pass_held"}, pass, exp_pass);
      check({name, "_timeout_held"}, timeout, exp_to);
      ev_cyc.delete();
      ev_byte.delete();
   endtask

   task automatic add_ev(input int c, input logic [7:0] b);
      ev_cyc.push_back(c);
      ev_byte.push_back(b);
   endtask

   initial begin
      msg[0] = 8'h4D; msg[1] = 8'h41; msg[2] = 8'h52; msg[3] = 8'h43; msg[4] = 8'h4F;
      rst_n = 1'b0; baud_tick = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      $display("[TB] start without baud ticks");
      do_start();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      check("no_tick_tx", tx, 1'b1);
      check("no_tick_busy", busy, 1'b1);
      run_send(1'b0, 1'b0);
      add_ev(10, 8'h50); add_ev(20, 8'h4F); add_ev(30, 8'h4C); add_ev(40, 8'h4F);
      run_wait("pass");

      $display("[TB] resync on repeated P");
      do_start();
      run_send(1'b0, 1'b0);
      add_ev(10, 8'h50); add_ev(15, 8'h50); add_ev(21, 8'h4F); add_ev(27, 8'h4C); add_ev(33, 8'h4F);
      run_wait("resync");

      $display("[TB] broken reply times out");
      do_start();
      run_send(1'b0, 1'b0);
      add_ev(10, 8'h50); add_ev(20, 8'h4F); add_ev(30, 8'h58); add_ev(40, 8'h4F);
      run_wait("timeout");

      $display("[TB] final byte on expiring tick");
      do_start();
      run_send(1'b0, 1'b0);
      add_ev(10, 8'h50); add_ev(20, 8'h4F); add_ev(30, 8'h4C); add_ev(4 * TO, 8'h4F);
      run_wait("collision");

      $display("[TB] start and bytes during SEND ignored");
      do_start();
      run_send(1'b1, 1'b1);
      run_wait("ignore");

      $display("[TB] reset during a data-0 bit");
      do_start();
      for (int c = 1; c <= 12; c++) applyStimulus(c % 4 == 0, 1'b0, 1'b0, 8'h00);
      check("pre_reset_tx_zero", tx, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_start();
      run_send(1'b0, 1'b0);
      add_ev(8, 8'h50); add_ev(9, 8'h4F); add_ev(10, 8'h4C); add_ev(11, 8'h4F);
      run_wait("after_reset");

      $display("[TB] randomized replies");
      for (int t = 0; t < 8; t++) begin
         do_start();
         run_send(1'b0, 1'b0);
         for (int c = 1; c <= 4 * TO + 4; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 4))
                  0: add_ev(c, 8'h50);
                  1: add_ev(c, 8'h4F);
                  2: add_ev(c, 8'h4C);
                  3: add_ev(c, 8'h58);
                  default: add_ev(c, 8'($urandom));
               endcase
            end
         end
         run_wait($sformatf("random%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
